// File: rtl/proc_pkg.sv
// Shared processor constants.
//   WORD_W              : native operand width of the datapath.
//   SRC_RF .. SRC_IMM   : forwarding-source indices used to drive an
//                         operand selector's in_sel.
//   state_e             : occupancy states of the elastic operand stage.
package proc_pkg;

  localparam int WORD_W = 16;

  localparam int SRC_RF    = 0;
  localparam int SRC_EXMEM = 1;
  localparam int SRC_MEMWB = 2;
  localparam int SRC_IMM   = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_FULL  = 2'd1,  // main register held
    ST_SKID  = 2'd2   // main and skid registers held
  } state_e;

endpackage

// File: rtl/operand_select_stage_mux_n.sv
// mux_n: purely combinational N:1 selector with out-of-range flag.
//   in_data [NUM_IN*WIDTH] : packed candidates, candidate k at [k*WIDTH +: WIDTH]
//   sel     [SEL_W]        : binary index
//   out_data[WIDTH]        : selected candidate, all-zero when sel >= NUM_IN
//   out_err                : 1 when sel >= NUM_IN
module mux_n #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  // Decoding by explicit compare (rather than indexing) keeps an unknown or
  // out-of-range select from ever producing X on the data path.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned;
    // a missing default in always_comb infers a latch.
    out_data = '0;
    out_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        out_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// operand_select_stage: N-input operand selector with a registered elastic
// output stage (main register + one skid register), flush and stall counter.
//   clk, rst (sync, active-high)
//   in_data/in_sel/in_valid/in_ready : upstream candidates, select, handshake
//   flush                            : drop every held entry
//   out_data/out_err/out_valid/out_ready : registered entry and handshake
//   stall_cnt                        : saturating count of stalled output cycles
module operand_select_stage
  import proc_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Entry layout: {err, data}
  typedef logic [WIDTH:0] entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  entry_t           new_entry;
  logic             accept;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (sel_data),
    .out_err  (sel_err)
  );

  assign new_entry = {sel_err, sel_data};

  // Ready depends only on registered state (and reset), never on out_ready,
  // so no combinational path crosses the stage.
  assign in_ready  = !rst && (state_q != ST_SKID);
  assign accept    = in_valid && in_ready;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign out_err   = main_q[WIDTH];
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && out_ready) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_SKID;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins: everything held or arriving is discarded, but the main
    // register keeps its last contents so out_data/out_err do not change.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/operand_select_stage.md
Name: operand_select_stage

Overview:
- Parametrised N-input operand selector with a registered, elastic output stage. Successor to the fixed 16-bit 4:1 combinational mux.
- Sits between the register-read/forwarding logic and the EX stage.
- Selects one of NUM_IN candidate operands (register file, EX/MEM/WB forwards, immediate), registers the result behind a valid/ready handshake with a 2-entry skid buffer, and supports pipeline flush.
- Reports out-of-range selects and counts output stall cycles.

Parameters:
- WIDTH, 16, operand width in bits.
- NUM_IN, 4, number of candidate inputs (>=2; need not be a power of two).
- SEL_W, $clog2(NUM_IN), select width (derived; do not override).
- CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_IN*WIDTH  packed candidates; candidate k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  binary index of the selected candidate.
- in_valid  in  1  upstream presents data and select.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  discard all held entries (branch/hazard squash).
- out_data  out  WIDTH  registered selected operand.
- out_err  out  1  registered flag: the entry's in_sel was >= NUM_IN.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  downstream accepts.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clocking and reset: single clock. rst is synchronous and active-high; it has priority over all other inputs.
- Reset values: out_valid=0, out_data=0, out_err=0, stall_cnt=0, skid entry empty. in_ready=0 while rst=1.
- Select:
  - Combinational pick of candidate in_sel.
  - in_sel >= NUM_IN selects all-zero data and sets that entry's err bit=1; otherwise err=0.
  - No X propagation.
- Accept: accept = in_valid && in_ready.
- Latency: an accepted entry appears on out_data exactly 1 cycle later if the stage was EMPTY, or if it was FULL and out_ready=1.
- Storage: main register (drives outputs) plus one skid register. Each entry holds {err, data}.
- States: EMPTY (none held), FULL (main held), SKID (main + skid held).
  - in_ready = !rst && state != SKID. It is a function of state only, with no combinational path from out_ready.
  - out_valid = state != EMPTY.
- Transitions (flush=0):
  - EMPTY: accept -> FULL, main <= new entry.
  - FULL, accept && out_ready -> FULL, main <= new entry.
  - FULL, accept && !out_ready -> SKID, skid <= new entry, main unchanged.
  - FULL, !accept && out_ready -> EMPTY.
  - FULL, otherwise -> hold.
  - SKID, out_ready -> FULL, main <= skid.
  - SKID, otherwise -> hold.
- Ordering: strict FIFO; no entry is reordered or duplicated.
- Flush:
  - flush=1 -> next state EMPTY. Any entry accepted in the same cycle is dropped.
  - out_data/out_err keep their last value but out_valid=0.
  - stall_cnt is not cleared.
  - in_ready=1 the cycle after the flush.
- stall_cnt:
  - Increments when out_valid && !out_ready and not flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Data hold: out_data and out_err are stable whenever out_valid=1 and out_ready=0.
- Reset mid-operation: any held entries are lost and all outputs take their reset values the cycle after rst is sampled.

Decomposition:
- Shared package proc_pkg: WORD_W=16 and the forwarding-source index constants (SRC_RF=0, SRC_EXMEM=1, SRC_MEMWB=2, SRC_IMM=3) used to drive in_sel.
- Sub-module mux_n: purely combinational parametrised N:1 selector with an out-of-range flag, reusable elsewhere.
- The skid/FSM logic stays in operand_select_stage.

Test Plan:
- Reset, then in_valid=1 with in_sel=2 and candidates {0x1111,0x2222,0x3333,0x4444}, out_ready=1 -> next cycle out_valid=1, out_data=0x3333, out_err=0; in_ready held at 1.
- Back-to-back stream of 8 entries, out_ready=1 always -> one output per cycle in input order, latency 1, stall_cnt=0.
- Backpressure: out_ready=0, push A then B -> state SKID, in_ready=0, out_data=A held. Raise out_ready for 2 cycles -> A, then B emitted, in_ready returns to 1. stall_cnt equals the number of low-ready cycles with out_valid=1.
- NUM_IN=5 instance, in_sel=6 -> out_data=0x0000, out_err=1. in_sel=4 -> candidate 4 emitted, out_err=0.
- Flush in SKID state, with a simultaneous in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear, stall_cnt retained.
- Hold out_ready=0 with out_valid=1 for 300 cycles at CNT_W=8 -> stall_cnt saturates at 255. Then rst for 1 cycle -> every output at its reset value.
